// File: rtl/nn_video_pkg.sv
// nn_video_pkg
// Shared types and constants for the NN video source path: transmitter FSM
// state encoding, default frame geometry and pixel widths.
package nn_video_pkg;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SOF    = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    EOF    = 3'd4,
    VBLANK = 3'd5
  } tx_state_t;

  // Default frame geometry
  localparam int LN_SIZE = 640;
  localparam int NUM_LN  = 480;

  // Pixel widths: 8-bit gray in, 3 x 10-bit channels out
  localparam int GRAY_W = 8;
  localparam int RGB_W  = 30;
  localparam int NUM_CH = 3;
  localparam int CH_W   = RGB_W / NUM_CH;

  // Larger of two ints, for sizing the shared blank counter
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gray8_to_rgb10.sv
// gray8_to_rgb10
// Combinational gray -> RGB expansion. Every channel carries the gray value
// left-justified in 10 bits (low bits zero), so a downstream RGB-to-gray
// stage recovers the original gray exactly.
// Ports:
//   gray : in,  GRAY_W  gray pixel
//   rgb  : out, RGB_W   {R, G, B}, R in the top channel
module gray8_to_rgb10
  import nn_video_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [RGB_W-1:0]  rgb
);

  localparam int PAD_W = CH_W - GRAY_W;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign rgb[c*CH_W +: CH_W] = {gray, {PAD_W{1'b0}}};
  end

endmodule

// File: rtl/gray_frame_tx.sv
// gray_frame_tx
// Replays gray frames from an external pixel memory as a framed 30-bit RGB
// stream (frame_start_pkt / dat_valid / frame_end_pkt).
// Ports:
//   Clk, Rst        : clock, synchronous active-high reset
//   run             : level; frames are sent back-to-back while high
//   pix_rd          : memory read strobe
//   pix_addr        : read address, row*LnSize+col
//   pix_data        : gray pixel, valid the cycle after pix_rd
//   rgb10           : {R,G,B} 10 bits each, 0 when dat_valid is low
//   dat_valid       : rgb10 carries a pixel
//   frame_start_pkt : 1-cycle start-of-frame pulse
//   frame_end_pkt   : 1-cycle end-of-frame pulse
//   busy            : FSM not idle
//   frame_cnt       : completed frames, wraps
module gray_frame_tx
  import nn_video_pkg::*;
#(
  parameter int LnSize = LN_SIZE,
  parameter int NumLn  = NUM_LN,
  parameter int HBlank = 16,
  parameter int VBlank = 64,
  parameter int AW     = 19
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              run,
  output logic              pix_rd,
  output logic [AW-1:0]     pix_addr,
  input  logic [GRAY_W-1:0] pix_data,
  output logic [RGB_W-1:0]  rgb10,
  output logic              dat_valid,
  output logic              frame_start_pkt,
  output logic              frame_end_pkt,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int CW = (LnSize > 1) ? $clog2(LnSize) : 1;
  localparam int RW = (NumLn > 1) ? $clog2(NumLn) : 1;
  localparam int BW = $clog2(imax(HBlank, VBlank) + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(LnSize - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NumLn - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'(HBlank - 1);
  localparam logic [BW-1:0] VB_LAST  = BW'(VBlank - 1);
  localparam logic [BW-1:0] EOF_LAST = BW'(1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] blank;   // shared by HBLANK, EOF and VBLANK
  logic [AW-1:0] addr;
  logic          rd_q;    // pix_rd delayed by the memory read latency
  logic          col_last, row_last, last_pix;
  logic [RGB_W-1:0] rgb_w;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign last_pix = (state == ACTIVE) && col_last && row_last;

  // ---------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt       = state;
    pix_rd          = 1'b0;
    frame_start_pkt = 1'b0;
    frame_end_pkt   = 1'b0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        if (run) state_nxt = SOF;
      end
      SOF: begin
        frame_start_pkt = 1'b1;
        state_nxt       = ACTIVE;
      end
      ACTIVE: begin
        pix_rd = 1'b1;
        if (col_last) state_nxt = row_last ? EOF : HBLANK;
      end
      HBLANK: begin
        if (blank == HB_LAST) state_nxt = ACTIVE;
      end
      EOF: begin
        // first cycle drains the last read, second one closes the frame
        if (blank == EOF_LAST) begin
          frame_end_pkt = 1'b1;
          state_nxt     = VBLANK;
        end
      end
      VBLANK: begin
        if (blank == VB_LAST) state_nxt = run ? SOF : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      blank     <= '0;
      addr      <= '0;
      rd_q      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      rd_q  <= pix_rd;
      case (state)
        SOF: begin
          col   <= '0;
          row   <= '0;
          blank <= '0;
          addr  <= '0;
        end
        ACTIVE: begin
          blank <= '0;
          if (!col_last) col <= col + 1'b1;
          // hold at the final address so the counter never wraps, even
          // when the frame exactly fills the address space
          if (!last_pix) addr <= addr + 1'b1;
        end
        HBLANK: begin
          if (blank == HB_LAST) begin
            blank <= '0;
            col   <= '0;
            row   <= row + 1'b1;
          end else begin
            blank <= blank + 1'b1;
          end
        end
        EOF: begin
          if (blank == EOF_LAST) begin
            blank     <= '0;
            frame_cnt <= frame_cnt + 1'b1;
          end else begin
            blank <= blank + 1'b1;
          end
        end
        VBLANK: begin
          blank <= (blank == VB_LAST) ? '0 : blank + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pix_addr  = addr;
  assign dat_valid = rd_q;

  // ---------------------------------------------------------------------
  // Pixel path. pix_data arrives in the same cycle as dat_valid, so the
  // expansion is gated by dat_valid rather than re-registered; rgb10 is 0
  // whenever no pixel is presented, including right after reset.
  // ---------------------------------------------------------------------
  gray8_to_rgb10 u_cvt (
    .gray (pix_data),
    .rgb  (rgb_w)
  );

  assign rgb10 = dat_valid ? rgb_w : '0;

endmodule
